// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks: transmitter state
// encoding, common keyboard commands and device responses.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    localparam logic [1:0] MAX_RETRIES = 2'd2;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser for one PS/2 line with single-cycle fall/rise strobes.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~level;
    assign rise  = ~prev_q & level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain pull-low enables.
// Define PS2_TX_RETRY_EN to resend the latched byte up to twice on NACK/timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [7:0]    data_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [3:0]    n_q;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          done_q;
    logic          err_q;

    logic clk_s, clk_fall, clk_rise;
    logic data_s, data_fall, data_rise;
    logic in_xfer, lines_idle, tmo_hit, nack, fail, can_retry, accept;
    logic unused_edges;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_clk_in),
        .level (clk_s),
        .fall  (clk_fall),
        .rise  (clk_rise)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_data_in),
        .level (data_s),
        .fall  (data_fall),
        .rise  (data_rise)
    );

    assign unused_edges = &{1'b0, clk_rise, data_fall, data_rise};

    assign accept     = (state == IDLE) && tx_valid;
    assign in_xfer    = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign lines_idle = clk_s & data_s;
    // A device clock edge on the terminal count wins; so does a completed handshake.
    assign tmo_hit    = in_xfer && !clk_fall && (tmo_cnt == TMO_LAST) &&
                        !((state == WAIT_IDLE) && lines_idle);
    assign nack       = (state == ACK) && clk_fall && data_s;
    assign fail       = nack || tmo_hit;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_q;

    assign can_retry = (retry_q < MAX_RETRIES);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            retry_q <= '0;
        end else if (fail && can_retry) begin
            retry_q <= retry_q + 2'd1;
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            n_q       <= '0;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (fail) begin
                data_oe_q <= 1'b0;
                tmo_cnt   <= '0;
                if (can_retry) begin
                    state    <= INHIBIT;
                    clk_oe_q <= 1'b1;
                    inh_cnt  <= '0;
                    shift_q  <= data_q;
                end else begin
                    state    <= IDLE;
                    clk_oe_q <= 1'b0;
                    err_q    <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            data_q   <= tx_data;
                            shift_q  <= tx_data;
                            par_q    <= odd_parity(tx_data);
                            inh_cnt  <= '0;
                            clk_oe_q <= 1'b1;
                            state    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            data_oe_q <= 1'b1;
                            state     <= REQ;
                        end else begin
                            inh_cnt <= inh_cnt + IW'(1);
                        end
                    end
                    REQ: begin
                        clk_oe_q <= 1'b0;
                        n_q      <= '0;
                        tmo_cnt  <= '0;
                        state    <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_fall) begin
                            tmo_cnt <= '0;
                            n_q     <= n_q + 4'd1;
                            if (n_q < 4'd8) begin
                                data_oe_q <= ~shift_q[0];
                                shift_q   <= {1'b0, shift_q[7:1]};
                            end else if (n_q == 4'd8) begin
                                data_oe_q <= ~par_q;
                            end else begin
                                data_oe_q <= 1'b0;
                                state     <= ACK;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            tmo_cnt <= '0;
                            n_q     <= n_q + 4'd1;
                            state   <= WAIT_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        if (lines_idle) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else if (clk_fall) begin
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed self-checking bench for ps2_host_tx with a simple PS/2 device model
// that clocks frames, records the line level on each low phase and ACKs/NACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned IC   = 25;
    localparam int unsigned TC   = 200;
    localparam int unsigned HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int unsigned ATTEMPTS = 3;
`else
    localparam int unsigned ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic       dev_clk;
    logic       dev_data;

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host pull-downs and the device drivers.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (IC),
        .TIMEOUT_CYCLES (TC),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for the request-to-send, then generate nfalls clock pulses.
    task automatic dev_frame(input int unsigned nfalls, input logic ack_bit,
                             output logic [9:0] bits, output logic start_ok,
                             output logic ok);
        int unsigned w = 0;
        ok = 1'b0;
        start_ok = 1'b0;
        bits = '0;
        while (!(!ps2_clk_oe && ps2_data_oe) && w < IC + 100) begin
            @(negedge clk);
            w++;
        end
        if (!ps2_clk_oe && ps2_data_oe) begin
            ok = 1'b1;
            repeat (HALF) @(negedge clk);
            start_ok = (ps2_data_in == 1'b0);
            for (int i = 0; i < int'(nfalls); i++) begin
                if (i == 10) dev_data = ack_bit;
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                if (i < 10) bits[i] = ps2_data_in;
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
            dev_data = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_hold: rdy/busy/coe/doe/done/err=%b want 100000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_release: rdy/busy/coe/doe/done/err=%b want 100000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err});
        end
    endtask

    task automatic test_send_ed();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int cnt = 0;
        logic [9:0] bits;
        logic sok, ok;
        send(CMD_SET_LED);
        while (ps2_clk_oe && !ps2_data_oe && cnt < int'(IC) + 10) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== int'(IC)) begin
            errors++; $display("FAIL inhibit_len: got %0d want %0d", cnt, IC);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            errors++; $display("FAIL req_start: coe/doe=%b want 11", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            errors++; $display("FAIL req_release: coe/doe=%b want 01", {ps2_clk_oe, ps2_data_oe});
        end
        dev_frame(11, 1'b0, bits, sok, ok);
        checks++;
        if ({ok, sok} !== 2'b11) begin
            errors++; $display("FAIL ed_start: ok/start=%b want 11", {ok, sok});
        end
        checks++;
        if (bits !== 10'h3ED) begin
            errors++; $display("FAIL ed_frame: got %h want 3ed", bits);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({done_cnt - d0, err_cnt - e0} !== {32'sd1, 32'sd0}) begin
            errors++; $display("FAIL ed_done: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL ed_idle: rdy/busy=%b want 10", {tx_ready, busy});
        end
    endtask

    task automatic test_parity();
        int d0 = done_cnt;
        int hi = 0;
        logic [9:0] bits;
        logic sok, ok;
        send(8'h01);
        @(negedge clk);
        tx_data = 8'hAA; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(11, 1'b0, bits, sok, ok);
        checks++;
        if (bits !== 10'h201 || !ok) begin
            errors++; $display("FAIL par_01: got %h ok %b want 201 ok 1", bits, ok);
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (ps2_clk_oe || busy) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL ignore_busy_valid: active cycles %0d want 0", hi);
        end
        send(8'h00);
        dev_frame(11, 1'b0, bits, sok, ok);
        checks++;
        if (bits !== 10'h300 || !ok) begin
            errors++; $display("FAIL par_00: got %h ok %b want 300 ok 1", bits, ok);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++; $display("FAIL par_done: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_nack();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [9:0] bits;
        logic sok, ok;
        send(CMD_ECHO);
        for (int a = 0; a < int'(ATTEMPTS); a++) begin
            dev_frame(11, 1'b1, bits, sok, ok);
            checks++;
            if (bits !== 10'h3EE || !ok) begin
                errors++; $display("FAIL nack_frame%0d: got %h ok %b want 3ee ok 1", a, bits, ok);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({err_cnt - e0, done_cnt - d0} !== {32'sd1, 32'sd0}) begin
            errors++; $display("FAIL nack_err: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            errors++; $display("FAIL nack_lines: coe/doe/rdy=%b want 001",
                               {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w = 0;
        int k = 0;
`ifdef PS2_TX_RETRY_EN
        int phases = 1;
        logic prev;
        send(8'h55);
        prev = ps2_clk_oe;
        while (!err && k < 4 * int'(TC + IC + 10)) begin
            @(negedge clk);
            k++;
            if (ps2_clk_oe && !prev) phases++;
            prev = ps2_clk_oe;
        end
        checks++;
        if (phases !== 3 || !err) begin
            errors++; $display("FAIL timeout_retries: phases %0d err %b want 3 1", phases, err);
        end
`else
        send(8'h55);
        while (ps2_clk_oe && w < int'(IC) + 10) begin
            @(negedge clk);
            w++;
        end
        while (!err && k < int'(TC) + 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== int'(TC)) begin
            errors++; $display("FAIL timeout_len: got %0d want %0d", k, TC);
        end
`endif
        @(negedge clk);
        checks++;
        if ({err, ps2_clk_oe, ps2_data_oe, tx_ready} !== 4'b0001) begin
            errors++; $display("FAIL timeout_after: err/coe/doe/rdy=%b want 0001",
                               {err, ps2_clk_oe, ps2_data_oe, tx_ready});
        end
        checks++;
        if ({err_cnt - e0, done_cnt - d0} !== {32'sd1, 32'sd0}) begin
            errors++; $display("FAIL timeout_err: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [9:0] bits;
        logic sok, ok;
        send(8'h5A);
        dev_frame(5, 1'b0, bits, sok, ok);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
            errors++; $display("FAIL rst_mid: coe/doe/rdy/busy=%b want 0010",
                               {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(CMD_RESET);
        dev_frame(11, 1'b0, bits, sok, ok);
        checks++;
        if (bits !== 10'h3FF || !ok || !sok) begin
            errors++; $display("FAIL rst_resend: got %h ok %b start %b want 3ff 1 1", bits, ok, sok);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({done_cnt - d0, err_cnt - e0} !== {32'sd1, 32'sd0}) begin
            errors++; $display("FAIL rst_done: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
